// File: rtl/idelay_load_sequencer.sv
// Stages per-lane delay loads on a shared bus and commits all lanes with one broadcast set strobe.
// Optional fine-field clamp and error flag enabled by defining IDELAY_FINE_CHECK_EN.
module idelay_load_sequencer #(
  parameter int         NUM_LANES   = 8,
  parameter int         LANE_BITS   = 3,
  parameter logic [7:0] DELAY_VALUE = 8'h00,
  parameter int         SET_GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_apply,
  input  logic [LANE_BITS-1:0] cmd_lane,
  input  logic [7:0]           cmd_delay,
  output logic [NUM_LANES-1:0] ld,
  output logic [7:0]           delay_out,
  output logic                 set,
  output logic [NUM_LANES-1:0] pending,
  output logic                 busy,
  output logic                 err_lane,
  output logic                 err_fine,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {IDLE, GAP, SET} state_t;

  localparam logic [LANE_BITS:0] LANE_LIMIT = (LANE_BITS+1)'(NUM_LANES);

  state_t         state_reg, state_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic           accept;
  logic           load_acc;
  logic           lane_ok;
  logic [7:0]     delay_fixed;
  logic [NUM_LANES-1:0] ld_next;

  assign accept   = cmd_valid & cmd_ready;
  assign load_acc = accept & ~cmd_apply;
  assign lane_ok  = {1'b0, cmd_lane} < LANE_LIMIT;

`ifdef IDELAY_FINE_CHECK_EN
  logic fine_bad;
  // Fine taps above 4 would overrun one coarse step, so clamp and flag them.
  assign fine_bad    = cmd_delay[2:0] > 3'd4;
  assign delay_fixed = fine_bad ? {cmd_delay[7:3], 3'd4} : cmd_delay;
`else
  assign delay_fixed = cmd_delay;
  assign err_fine    = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_ld
      assign ld_next[gi] = load_acc && lane_ok && (cmd_lane == LANE_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept && cmd_apply) begin
          state_next = GAP;
          cnt_next   = 4'(SET_GAP);
        end
      end
      GAP: begin
        if (cnt_reg <= 4'd1) state_next = SET;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      SET:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      set       <= 1'b0;
      ld        <= '0;
      pending   <= '0;
      delay_out <= DELAY_VALUE;
      err_lane  <= 1'b0;
    end else begin
      cmd_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      set       <= (state_next == SET);
      ld        <= ld_next;
      if (load_acc && lane_ok) delay_out <= delay_fixed;
      if (state_next == SET) pending <= '0;
      else                   pending <= pending | ld_next;
      err_lane  <= (load_acc && !lane_ok) || (err_lane && !err_clr);
    end
  end

`ifdef IDELAY_FINE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_fine <= 1'b0;
    end else begin
      err_fine <= (load_acc && fine_bad) || (err_fine && !err_clr);
`ifdef IVERILOG
      if (load_acc && fine_bad)
        $display("idelay_load_sequencer: fine field %0d clamped to 4 at %0t", cmd_delay[2:0], $time);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_idelay_load_sequencer.sv
// Directed self-checking bench for idelay_load_sequencer (NUM_LANES=8, LANE_BITS=4, SET_GAP=2).
module tb_idelay_load_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_apply;
  logic [3:0] cmd_lane;
  logic [7:0] cmd_delay;
  logic [7:0] ld;
  logic [7:0] delay_out;
  logic       set;
  logic [7:0] pending;
  logic       busy;
  logic       err_lane;
  logic       err_fine;
  logic       err_clr;

  int total = 0;
  int fails = 0;

  idelay_load_sequencer #(
    .NUM_LANES(8), .LANE_BITS(4), .DELAY_VALUE(8'h00), .SET_GAP(2)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_apply(cmd_apply), .cmd_lane(cmd_lane), .cmd_delay(cmd_delay),
    .ld(ld), .delay_out(delay_out), .set(set), .pending(pending),
    .busy(busy), .err_lane(err_lane), .err_fine(err_fine), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic a, input logic [3:0] l, input logic [7:0] d);
    cmd_valid = v; cmd_apply = a; cmd_lane = l; cmd_delay = d;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step(); step();
    rst = 1'b0;
    step();
    check("rst_ready", cmd_ready, 1);
    check("rst_delay", delay_out, 8'h00);
    check("rst_ld", ld, 0);
    check("rst_set", set, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    check("rst_err_lane", err_lane, 0);
    check("rst_err_fine", err_fine, 0);

    // back-to-back loads
    drive(1'b1, 1'b0, 4'd3, 8'h2A);
    step();
    check("ld3_ld", ld, 8'h08);
    check("ld3_delay", delay_out, 8'h2A);
    check("ld3_pending", pending, 8'h08);
    drive(1'b1, 1'b0, 4'd5, 8'h11);
    step();
    check("ld5_ld", ld, 8'h20);
    check("ld5_delay", delay_out, 8'h11);
    check("ld5_pending", pending, 8'h28);
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    check("ld_idle_ld", ld, 0);
    check("ld_idle_delay", delay_out, 8'h11);

    // apply with cmd_valid held throughout
    drive(1'b1, 1'b1, 4'd0, 8'h00);
    step();
    check("ap1_busy", busy, 1);
    check("ap1_ready", cmd_ready, 0);
    check("ap1_set", set, 0);
    step();
    check("ap2_busy", busy, 1);
    check("ap2_set", set, 0);
    check("ap2_pending", pending, 8'h28);
    step();
    check("ap3_set", set, 1);
    check("ap3_pending", pending, 0);
    check("ap3_ready", cmd_ready, 0);
    step();
    check("ap4_ready", cmd_ready, 1);
    check("ap4_busy", busy, 0);
    check("ap4_set", set, 0);
    step();
    check("held_busy", busy, 1);
    check("held_ready", cmd_ready, 0);
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    step();
    check("held_set", set, 1);
    step();
    check("held_done_ready", cmd_ready, 1);

    // out-of-range lane
    drive(1'b1, 1'b0, 4'd9, 8'h55);
    step();
    check("oor_ld", ld, 0);
    check("oor_err", err_lane, 1);
    check("oor_pending", pending, 0);
    check("oor_delay", delay_out, 8'h11);
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err", err_lane, 0);

    // fine field
    drive(1'b1, 1'b0, 4'd0, 8'h0F);
    step();
    check("fine_ld", ld, 8'h01);
`ifdef IDELAY_FINE_CHECK_EN
    check("fine_delay", delay_out, 8'h0C);
    check("fine_err", err_fine, 1);
`else
    check("fine_delay", delay_out, 8'h0F);
    check("fine_err", err_fine, 0);
`endif
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    check("fine_pending", pending, 8'h01);

    // reset during GAP
    drive(1'b1, 1'b1, 4'd0, 8'h00);
    step();
    check("gap_busy", busy, 1);
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", cmd_ready, 1);
    check("arst_pending", pending, 0);
    check("arst_delay", delay_out, 8'h00);
    check("arst_err_fine", err_fine, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_noset", set, 0);
    end
    drive(1'b1, 1'b1, 4'd0, 8'h00);
    step();
    check("re_busy", busy, 1);
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    check("re_set_early", set, 0);
    step();
    check("re_set", set, 1);
    step();
    check("re_ready", cmd_ready, 1);
    check("re_busy_done", busy, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
